ps2_direction_decoder: RTL and testbench
========================================

# ps2_direction_decoder

Front end of the game datapath, upstream of the game-logic FSM. Receives raw PS/2 keyboard frames, validates them, decodes make/break and extended scan-code sequences, and maps arrow keys and WASD onto the 3-bit player direction code. Also generates the periodic movement tick (`hs_enable`) that paces player and ghost updates. Outputs feed the game logic's `last_key_received`, `direction` and `hs_enable` inputs directly.

## Interface

Parameters:
- `FILTER_LEN`, default 8: cycles the synchronized PS/2 clock must hold a level before the filtered clock follows it.
- `TIMEOUT_CYCLES`, default 50000: idle cycles mid-frame before the frame is abandoned.
- `TICK_CYCLES`, default 12500000: `hs_enable` period in clock cycles; must be ≥ 2.
- `STICKY`, default 0: 1 makes break codes leave `direction` unchanged.

Ports:
- `clock` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `PS2_CLK` in 1: keyboard clock, asynchronous.
- `PS2_DAT` in 1: keyboard data, asynchronous.
- `last_key_received` out 8: scan code of the most recent mapped make event.
- `direction` out 3: still=000, up=001, left=010, down=011, right=100.
- `key_valid` out 1: one-cycle pulse when `direction` or `last_key_received` is updated by an event.
- `frame_error` out 1: one-cycle pulse on parity, stop or timeout error.
- `hs_enable` out 1: one-cycle movement tick, period `TICK_CYCLES`.

## Operation

- **Reset values.** `last_key_received`=0x00, `direction`=000. `key_valid`, `frame_error` and `hs_enable` are 0. All counters are 0. Prefix flags `ext` and `brk` are clear. The filtered clock is 1 and the receiver is in IDLE.
- **Input conditioning.** `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchronizer. A glitch filter with a counter of width clog2(`FILTER_LEN`)+1 drives the filtered clock. A falling edge of the filtered clock is a sample strobe.
- **Receiver FSM.** States IDLE → DATA → PARITY → STOP → IDLE. All transitions happen on the sample strobe.
  - IDLE: a sampled data value of 0 (start bit) moves to DATA. A sampled 1 stays in IDLE.
  - DATA: shifts in 8 bits, LSB first. A 3-bit counter tracks the bits; it wraps 7 → 0 and the FSM moves to PARITY.
  - PARITY: captures the parity bit.
  - STOP: the frame is good if the stop bit is 1 and the 9 bits (data plus parity) have odd parity. A good frame raises an internal one-cycle `byte_valid`. A bad frame pulses `frame_error`.
  - Timeout: in any non-IDLE state, a 16-bit counter counts cycles since the last strobe. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, pulses `frame_error` and discards partial data.
- **Scan-code decoder.** It acts on each `byte_valid`:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte is a key event with the current `ext` and `brk`. It then clears both flags.
  - Any `frame_error` also clears both flags.
- **Key mapping.**
  - Extended: 0x75 → up, 0x6B → left, 0x72 → down, 0x74 → right.
  - Non-extended: 0x1D → up, 0x1C → left, 0x1B → down, 0x23 → right.
  - All other codes are ignored, with no `key_valid`.
- **Make event of a mapped key.** `direction` takes the mapped value, `last_key_received` takes the code, and `key_valid` pulses.
- **Break event with `STICKY`=0.** The event counts only if the code equals `last_key_received` and the mapping matches the current `direction`. Then `direction` becomes still, `last_key_received` is unchanged and `key_valid` pulses. Breaks of other keys are ignored.
- **Break event with `STICKY`=1.** All breaks are ignored.
- **Tick generator.** A free-running 24-bit counter counts 0 … `TICK_CYCLES`−1 and then wraps to 0. `hs_enable` is 1 exactly in the cycle the counter equals `TICK_CYCLES`−1. The tick generator is independent of keyboard activity.

## Timing

- **Filter.** The filtered clock changes `FILTER_LEN` cycles after the synchronized clock settles at a new level. Any bounce restarts the count.
- **End-to-end latency.** From a stop-bit falling edge on `PS2_CLK` to `byte_valid`: 2 (sync) + `FILTER_LEN` + 1 (edge detect) + 1 cycles.
- **Decoder latency.** `key_valid`, `direction` and `last_key_received` update in the cycle after `byte_valid`. All outputs are registered.
- **Simultaneous events.**
  - `hs_enable` and `key_valid` may coincide. The game logic sees the new `direction` in that same cycle.
  - A `frame_error` and a `byte_valid` cannot occur in the same cycle.
- **Reset mid-frame.** Reset takes effect immediately and asynchronously. The partial frame is lost. The next start bit is decoded normally.

## Test plan

- **Arrow keys.** Send frames 0xE0, 0x75. `direction`=001 and `last_key_received`=0x75, one `key_valid` pulse. Then send 0xE0, 0xF0, 0x75. `direction`=000 and `last_key_received` stays 0x75.
- **WASD and break of a non-held key.** Send 0x1C, giving `direction`=010. Then send 0x23, giving `direction`=100 and `last_key_received`=0x23. Then send 0xF0, 0x1C. `direction` stays 100 with no `key_valid`. Repeat with `STICKY`=1: breaking 0x23 leaves 100.
- **Parity error.** Send 0xE0, then 0x75 with the parity bit flipped. Expect one `frame_error` pulse and no `direction` change. A following 0x72 (non-extended, unmapped) gives no `key_valid`, which confirms `ext` was cleared.
- **Timeout and glitch.**
  - Stop `PS2_CLK` after 4 data bits for `TIMEOUT_CYCLES`+10 cycles. Expect one `frame_error`, after which a full 0x1D frame gives `direction`=001.
  - Separately, inject a 3-cycle low glitch on `PS2_CLK` with `FILTER_LEN`=8. Expect no sample taken.
- **Tick generator.** With `TICK_CYCLES`=5, `hs_enable` pulses at cycles 4, 9 and 14 after reset release. Assert reset at cycle 7; the next pulse is 5 cycles after release.

Source files
------------

// File: rtl/ps2_direction_decoder_if.sv
// Groups the PS/2 pins and the game-facing outputs of ps2_direction_decoder.
// master: decoder side (samples the pins, drives direction/strobes).
// slave: keyboard/game side (drives the pins, observes the outputs).
interface ps2_direction_decoder_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] last_key_received;
    logic [2:0] direction;
    logic       key_valid;
    logic       frame_error;
    logic       hs_enable;

    modport master (
        input  PS2_CLK,
        input  PS2_DAT,
        output last_key_received,
        output direction,
        output key_valid,
        output frame_error,
        output hs_enable
    );

    modport slave (
        output PS2_CLK,
        output PS2_DAT,
        input  last_key_received,
        input  direction,
        input  key_valid,
        input  frame_error,
        input  hs_enable
    );
endinterface

// File: rtl/ps2_direction_decoder.sv
// PS/2 receiver + scan-code decoder mapping arrows/WASD to a 3-bit direction, plus movement tick.
// Latency: stop-bit PS2_CLK fall to byte_valid = 2 + FILTER_LEN + 2 cycles; outputs one cycle later.
// No backpressure: every event is reported once via one-cycle pulses; the keyboard cannot be stalled.
module ps2_direction_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TICK_CYCLES    = 12500000,
    parameter bit STICKY         = 1'b0
) (
    input  logic                          clock,
    input  logic                          reset,
    ps2_direction_decoder_if.master       bus
);
    localparam int              FW        = $clog2(FILTER_LEN) + 1;
    localparam logic [FW-1:0]   FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [15:0]     TOUT_MAX  = 16'(TIMEOUT_CYCLES);
    localparam logic [23:0]     TICK_LAST = 24'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_clk_q, filt_prev_q, strobe_q;
    rx_state_t     rx_state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [15:0]   tout_q;
    logic          byte_valid_q, ferr_q;
    logic          ext_q, brk_q;
    logic [2:0]    dir_q;
    logic [7:0]    last_q;
    logic          kv_q;
    logic [23:0]   tick_q, tick_d;
    logic          hs_q;
    logic [3:0]    key_map;   // {mapped, direction} for the byte just received

    // Two-flop synchronizers; idle-high reset value so reset never looks like a start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], bus.PS2_DAT};
        end
    end

    // Glitch filter: follow the synced clock only after FILTER_LEN stable cycles; registered falling-edge strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            strobe_q    <= 1'b0;
        end else begin
            filt_prev_q <= filt_clk_q;
            strobe_q    <= filt_prev_q & ~filt_clk_q;
            if (clk_sync_q[1] == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_clk_q <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // Receiver FSM: start, 8 data bits LSB first, odd parity, stop; timeout abandons a stalled frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q   <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tout_q       <= 16'd0;
            byte_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
            if (strobe_q) begin
                tout_q <= 16'd0;
                case (rx_state_q)
                    S_IDLE: begin
                        if (!dat_sync_q[1]) begin
                            rx_state_q <= S_DATA;
                            bit_cnt_q  <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift_q   <= {dat_sync_q[1], shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_q      <= dat_sync_q[1];
                        rx_state_q <= S_STOP;
                    end
                    default: begin
                        if (dat_sync_q[1] && (^{shift_q, par_q})) byte_valid_q <= 1'b1;
                        else                                       ferr_q       <= 1'b1;
                        rx_state_q <= S_IDLE;
                    end
                endcase
            end else if (rx_state_q != S_IDLE) begin
                if (tout_q == TOUT_MAX) begin
                    rx_state_q <= S_IDLE;
                    bit_cnt_q  <= 3'd0;
                    shift_q    <= 8'h00;
                    tout_q     <= 16'd0;
                    ferr_q     <= 1'b1;
                end else begin
                    tout_q <= tout_q + 16'd1;
                end
            end
        end
    end

    // Scan-code to direction lookup; bit 3 flags a mapped key.
    function automatic logic [3:0] map_key(input logic ext, input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        if (ext) begin
            case (code)
                8'h75: m = 4'b1_001;
                8'h6B: m = 4'b1_010;
                8'h72: m = 4'b1_011;
                8'h74: m = 4'b1_100;
                default: m = 4'b0000;
            endcase
        end else begin
            case (code)
                8'h1D: m = 4'b1_001;
                8'h1C: m = 4'b1_010;
                8'h1B: m = 4'b1_011;
                8'h23: m = 4'b1_100;
                default: m = 4'b0000;
            endcase
        end
        return m;
    endfunction

    assign key_map = map_key(ext_q, shift_q);

    // Decoder: track E0/F0 prefixes, apply make events, and release only on a break of the held key.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            dir_q  <= 3'b000;
            last_q <= 8'h00;
            kv_q   <= 1'b0;
        end else begin
            kv_q <= 1'b0;
            if (ferr_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_valid_q) begin
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (key_map[3]) begin
                        if (!brk_q) begin
                            dir_q  <= key_map[2:0];
                            last_q <= shift_q;
                            kv_q   <= 1'b1;
                        end else if (!STICKY && shift_q == last_q && key_map[2:0] == dir_q) begin
                            dir_q <= 3'b000;
                            kv_q  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Next tick count: wrap after TICK_CYCLES-1.
    always_comb begin
        tick_d = (tick_q == TICK_LAST) ? 24'd0 : tick_q + 24'd1;
    end

    // Free-running tick; hs_enable registered so it is high while the count equals TICK_CYCLES-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q <= 24'd0;
            hs_q   <= 1'b0;
        end else begin
            tick_q <= tick_d;
            hs_q   <= (tick_d == TICK_LAST);
        end
    end

    assign bus.last_key_received = last_q;
    assign bus.direction         = dir_q;
    assign bus.key_valid         = kv_q;
    assign bus.frame_error       = ferr_q;
    assign bus.hs_enable         = hs_q;
endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench: two decoders (STICKY=0 and STICKY=1) share one PS/2 stimulus.
// Table of frames with hand-computed direction/last-key/pulse counts, plus timeout,
// glitch, reset-mid-frame and tick sequences.
module tb_ps2_direction_decoder;
    localparam int HP      = 20;    // PS/2 half bit period in core clocks
    localparam int TIMEOUT = 200;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    int n_vec = 0;
    int n_bad = 0;
    int kv_tot = 0;
    int fe_tot = 0;

    ps2_direction_decoder_if bus0();
    ps2_direction_decoder_if bus1();

    assign bus0.PS2_CLK = ps2_clk;
    assign bus0.PS2_DAT = ps2_dat;
    assign bus1.PS2_CLK = ps2_clk;
    assign bus1.PS2_DAT = ps2_dat;

    ps2_direction_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT), .TICK_CYCLES(5), .STICKY(1'b0))
        u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
    ps2_direction_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT), .TICK_CYCLES(5), .STICKY(1'b1))
        u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus0.key_valid)   kv_tot++;
        if (bus0.frame_error) fe_tot++;
    end

    typedef struct {
        logic [7:0] code;
        logic       bad;
        int         kv;
        int         fe;
        logic [2:0] dir;
        logic [7:0] last;
        logic [2:0] dir_s;
    } vec_t;

    vec_t vt[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (HP) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (HP) @(negedge clock);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad);
        send_bits(frame_of(b, bad), 11);
        ps2_dat = 1'b1;
        repeat (40) @(negedge clock);
    endtask

    task automatic check_state(input string tag, input int kv0, input int fe0, input int kv, input int fe,
                               input logic [2:0] dir, input logic [7:0] last, input logic [2:0] dir_s);
        check({tag, " key_valid count"}, 32'(kv_tot - kv0), 32'(kv));
        check({tag, " frame_error count"}, 32'(fe_tot - fe0), 32'(fe));
        check({tag, " direction"}, 32'(bus0.direction), 32'(dir));
        check({tag, " last_key"}, 32'(bus0.last_key_received), 32'(last));
        check({tag, " sticky direction"}, 32'(bus1.direction), 32'(dir_s));
    endtask

    initial begin
        int kv0, fe0;
        //        code   bad  kv fe dir     last   dir_s
        vt[0]  = '{8'hE0, 1'b0, 0, 0, 3'd0, 8'h00, 3'd0};
        vt[1]  = '{8'h75, 1'b0, 1, 0, 3'd1, 8'h75, 3'd1};
        vt[2]  = '{8'hE0, 1'b0, 0, 0, 3'd1, 8'h75, 3'd1};
        vt[3]  = '{8'hF0, 1'b0, 0, 0, 3'd1, 8'h75, 3'd1};
        vt[4]  = '{8'h75, 1'b0, 1, 0, 3'd0, 8'h75, 3'd1};
        vt[5]  = '{8'h1C, 1'b0, 1, 0, 3'd2, 8'h1C, 3'd2};
        vt[6]  = '{8'h23, 1'b0, 1, 0, 3'd4, 8'h23, 3'd4};
        vt[7]  = '{8'hF0, 1'b0, 0, 0, 3'd4, 8'h23, 3'd4};
        vt[8]  = '{8'h1C, 1'b0, 0, 0, 3'd4, 8'h23, 3'd4};
        vt[9]  = '{8'hF0, 1'b0, 0, 0, 3'd4, 8'h23, 3'd4};
        vt[10] = '{8'h23, 1'b0, 1, 0, 3'd0, 8'h23, 3'd4};
        vt[11] = '{8'hE0, 1'b0, 0, 0, 3'd0, 8'h23, 3'd4};
        vt[12] = '{8'h75, 1'b1, 0, 1, 3'd0, 8'h23, 3'd4};
        vt[13] = '{8'h72, 1'b0, 0, 0, 3'd0, 8'h23, 3'd4};
        vt[14] = '{8'h1D, 1'b0, 1, 0, 3'd1, 8'h1D, 3'd1};
        vt[15] = '{8'h6B, 1'b0, 0, 0, 3'd1, 8'h1D, 3'd1};
        vt[16] = '{8'hE0, 1'b0, 0, 0, 3'd1, 8'h1D, 3'd1};
        vt[17] = '{8'h6B, 1'b0, 1, 0, 3'd2, 8'h6B, 3'd2};
        vt[18] = '{8'hE0, 1'b0, 0, 0, 3'd2, 8'h6B, 3'd2};
        vt[19] = '{8'h74, 1'b0, 1, 0, 3'd4, 8'h74, 3'd4};
        vt[20] = '{8'hE0, 1'b0, 0, 0, 3'd4, 8'h74, 3'd4};
        vt[21] = '{8'h72, 1'b0, 1, 0, 3'd3, 8'h72, 3'd3};

        // Reset values.
        repeat (3) @(negedge clock);
        check("reset direction", 32'(bus0.direction), 32'd0);
        check("reset last_key", 32'(bus0.last_key_received), 32'h00);
        check("reset key_valid", 32'(bus0.key_valid), 32'd0);
        check("reset frame_error", 32'(bus0.frame_error), 32'd0);
        check("reset hs_enable", 32'(bus0.hs_enable), 32'd0);

        // Tick: pulse at cycle 4 after release, then reset at cycle 7.
        reset = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            check($sformatf("tick run1 cycle %0d", k), 32'(bus0.hs_enable), 32'(k % 5 == 4));
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        check("tick during reset", 32'(bus0.hs_enable), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            check($sformatf("tick run2 cycle %0d", k), 32'(bus0.hs_enable), 32'(k % 5 == 4));
            @(negedge clock);
        end

        // Table-driven frames.
        for (int v = 0; v < 22; v++) begin
            kv0 = kv_tot;
            fe0 = fe_tot;
            send_byte(vt[v].code, vt[v].bad);
            check_state($sformatf("vec%0d", v), kv0, fe0, vt[v].kv, vt[v].fe,
                        vt[v].dir, vt[v].last, vt[v].dir_s);
        end

        // Timeout: stall after 4 data bits, then a clean 0x1D frame.
        kv0 = kv_tot;
        fe0 = fe_tot;
        send_bits(frame_of(8'h1D, 1'b0), 5);
        ps2_dat = 1'b1;
        repeat (TIMEOUT + 10) @(negedge clock);
        check_state("timeout", kv0, fe0, 0, 1, 3'd3, 8'h72, 3'd3);
        kv0 = kv_tot;
        fe0 = fe_tot;
        send_byte(8'h1D, 1'b0);
        check_state("after timeout", kv0, fe0, 1, 0, 3'd1, 8'h1D, 3'd1);

        // 3-cycle low glitch with data low must not be taken as a start bit.
        kv0 = kv_tot;
        fe0 = fe_tot;
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clock);
        ps2_dat = 1'b1;
        repeat (10) @(negedge clock);
        send_byte(8'h1B, 1'b0);
        check_state("after glitch", kv0, fe0, 1, 0, 3'd3, 8'h1B, 3'd3);

        // Reset mid-frame, then a normal frame.
        send_bits(frame_of(8'h23, 1'b0), 4);
        reset = 1'b1;
        #1;
        check("midframe reset direction", 32'(bus0.direction), 32'd0);
        check("midframe reset last_key", 32'(bus0.last_key_received), 32'h00);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        kv0 = kv_tot;
        fe0 = fe_tot;
        send_byte(8'h23, 1'b0);
        check_state("after reset", kv0, fe0, 1, 0, 3'd4, 8'h23, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
